// File: rtl/dom_unmask_d1.sv
// Purpose: recombine a two-share Boolean-masked word into plaintext, refreshing each share before the XOR.
// Latency: input handshake at edge N -> out_valid high after edge N+1; one word in flight, 3-cycle minimum issue interval.
// Backpressure: out_valid/out_data held stable while out_ready=0; in_ready is low until the output word is taken.
module dom_unmask_d1 #(
    parameter int W     = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_s0,
    input  logic [W-1:0]     in_s1,
    input  logic [W-1:0]     in_r,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic             busy,
    output logic [CNT_W-1:0] done_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMBINE = 2'd1,
        OUT     = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Refreshed shares live in separate registers so the two raw shares never
    // share a logic cone before being registered; keep stops synthesis merging them.
    (* keep = "true" *) logic [W-1:0] a_q;
    (* keep = "true" *) logic [W-1:0] b_q;
    (* keep = "true" *) logic [W-1:0] data_q;
    logic [W-1:0]     a_d, b_d, data_d;
    logic [CNT_W-1:0] done_cnt_q, done_cnt_d;

    // Next-state and register updates; clear overrides any handshake in the same cycle.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        data_d     = data_q;
        done_cnt_d = done_cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = in_s0 ^ in_r;
                    b_d     = in_s1 ^ in_r;
                    state_d = COMBINE;
                end
            end
            COMBINE: begin
                data_d  = a_q ^ b_q;
                a_d     = '0;
                b_d     = '0;
                state_d = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    data_d     = '0;
                    done_cnt_d = done_cnt_q + CNT_W'(1);
                    state_d    = IDLE;
                end
            end
            default: begin
                a_d     = '0;
                b_d     = '0;
                data_d  = '0;
                state_d = IDLE;
            end
        endcase
        if (clear) begin
            state_d    = IDLE;
            a_d        = '0;
            b_d        = '0;
            data_d     = '0;
            done_cnt_d = done_cnt_q;
        end
    end

    // State and datapath registers; reset drops any in-flight word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            data_q     <= '0;
            done_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            data_q     <= data_d;
            done_cnt_q <= done_cnt_d;
        end
    end

    // Outputs decode from registers only; plaintext is gated to zero outside OUT.
    always_comb begin
        in_ready  = (state_q == IDLE);
        busy      = (state_q != IDLE);
        out_valid = (state_q == OUT);
        out_data  = (state_q == OUT) ? data_q : '0;
        done_cnt  = done_cnt_q;
    end

endmodule

// File: tb/tb_dom_unmask_d1.sv
// Purpose: directed self-checking bench for dom_unmask_d1.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: out_ready driven directly by each scenario.
module tb_dom_unmask_d1;

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_s0;
    logic [7:0] in_s1;
    logic [7:0] in_r;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       busy;
    logic [7:0] done_cnt;

    int checks;
    int errors;
    int cyc;

    dom_unmask_d1 #(.W(8), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_s0     (in_s0),
        .in_s1     (in_s1),
        .in_r      (in_r),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .done_cnt  (done_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Present one share pair for exactly one accepting edge.
    task automatic send(input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] r);
        in_s0    = s0;
        in_s1    = s1;
        in_r     = r;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_s0 = 8'h00; in_s1 = 8'h00; in_r = 8'h00;
        step(); step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %h want 00", out_data); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
        checks++; if (done_cnt !== 8'h00) begin errors++; $display("FAIL reset_done_cnt got %0d want 0", done_cnt); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_wrap();
        logic [7:0] s0, s1, exp;
        int last_rise, min_gap, bad;
        last_rise = -1; min_gap = 1000; bad = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            if (in_ready !== 1'b1) bad++;
            if (last_rise >= 0 && (cyc - last_rise) < min_gap) min_gap = cyc - last_rise;
            last_rise = cyc;
            s0  = 8'($urandom_range(0, 255));
            s1  = 8'($urandom_range(0, 255));
            exp = s0 ^ s1;
            in_s0 = s0; in_s1 = s1; in_r = 8'($urandom_range(0, 255));
            in_valid = 1'b1;
            step();                          // accepted, now COMBINE
            in_valid = 1'b1;                 // kept high: must not be accepted again
            in_s0 = ~s0;
            step();                          // now OUT
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp) begin
                errors++;
                $display("FAIL wrap_data[%0d] got v=%0b d=%h want v=1 d=%h", i, out_valid, out_data, exp);
            end
            step();                          // output taken, back to IDLE
        end
        in_valid = 1'b0;
        checks++; if (bad != 0) begin errors++; $display("FAIL wrap_in_ready got %0d low samples want 0", bad); end
        checks++; if (min_gap != 3) begin errors++; $display("FAIL wrap_min_interval got %0d want 3", min_gap); end
        checks++; if (done_cnt !== 8'h00) begin errors++; $display("FAIL wrap_done_cnt got %0d want 0", done_cnt); end
        out_ready = 1'b0;
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        send(8'h5A, 8'h3C, 8'hFF);
        checks++; if (in_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL basic_combine got rdy=%0b busy=%0b want rdy=0 busy=1", in_ready, busy); end
        checks++; if (out_valid !== 1'b0 || out_data !== 8'h00) begin errors++; $display("FAIL basic_early got v=%0b d=%h want v=0 d=00", out_valid, out_data); end
        step();
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h66) begin errors++; $display("FAIL basic_out got v=%0b d=%h want v=1 d=66", out_valid, out_data); end
        checks++; if (in_ready !== 1'b0 || done_cnt !== 8'd0) begin errors++; $display("FAIL basic_busy got rdy=%0b cnt=%0d want rdy=0 cnt=0", in_ready, done_cnt); end
        step();
        checks++; if (done_cnt !== 8'd1 || in_ready !== 1'b1 || out_data !== 8'h00) begin errors++; $display("FAIL basic_done got cnt=%0d rdy=%0b d=%h want cnt=1 rdy=1 d=00", done_cnt, in_ready, out_data); end
        out_ready = 1'b0;
    endtask

    task automatic test_rand_indep();
        logic [7:0] rs [2];
        rs[0] = 8'h00; rs[1] = 8'hA5;
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            send(8'h5A, 8'h3C, rs[i]);
            step();
            checks++; if (out_data !== 8'h66) begin errors++; $display("FAIL rand_indep r=%h got %h want 66", rs[i], out_data); end
            step();
        end
        checks++; if (done_cnt !== 8'd3) begin errors++; $display("FAIL rand_indep_cnt got %0d want 3", done_cnt); end
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int bad;
        bad = 0;
        out_ready = 1'b0;
        send(8'h5A, 8'h3C, 8'h11);
        step();                              // out_valid now high
        for (int i = 0; i < 5; i++) begin
            in_s0 = 8'(i * 37); in_r = 8'(i * 91); in_valid = i[0];
            if (out_valid !== 1'b1 || out_data !== 8'h66 || in_ready !== 1'b0) bad++;
            step();
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL bp_hold got %0d bad samples want 0", bad); end
        checks++; if (out_data !== 8'h66 || done_cnt !== 8'd3) begin errors++; $display("FAIL bp_stall got d=%h cnt=%0d want d=66 cnt=3", out_data, done_cnt); end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0 || out_data !== 8'h00 || in_ready !== 1'b1 || done_cnt !== 8'd4) begin
            errors++; $display("FAIL bp_release got v=%0b d=%h rdy=%0b cnt=%0d want v=0 d=00 rdy=1 cnt=4", out_valid, out_data, in_ready, done_cnt);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_clear_collision();
        out_ready = 1'b0;
        send(8'hF0, 8'h0F, 8'h33);
        step();                              // OUT
        clear = 1'b1; out_ready = 1'b1;
        step();
        clear = 1'b0; out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || out_data !== 8'h00 || in_ready !== 1'b1) begin errors++; $display("FAIL clr_out got v=%0b d=%h rdy=%0b want v=0 d=00 rdy=1", out_valid, out_data, in_ready); end
        checks++; if (done_cnt !== 8'd4) begin errors++; $display("FAIL clr_cnt got %0d want 4", done_cnt); end
        // clear also wins over an input handshake in IDLE
        clear = 1'b1;
        send(8'h12, 8'h34, 8'h56);
        clear = 1'b0;
        checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL clr_in got busy=%0b rdy=%0b want busy=0 rdy=1", busy, in_ready); end
        step(); step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clr_in_ghost got v=%0b want 0", out_valid); end
        out_ready = 1'b1;
        send(8'hC3, 8'h81, 8'h7E);
        step();
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h42) begin errors++; $display("FAIL clr_after got v=%0b d=%h want v=1 d=42", out_valid, out_data); end
        step();
        checks++; if (done_cnt !== 8'd5) begin errors++; $display("FAIL clr_after_cnt got %0d want 5", done_cnt); end
        out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        out_ready = 1'b1;
        send(8'hAA, 8'h55, 8'h0F);           // now COMBINE
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_data !== 8'h00) begin errors++; $display("FAIL arst_out got v=%0b d=%h want v=0 d=00", out_valid, out_data); end
        checks++; if (done_cnt !== 8'd0 || in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL arst_state got cnt=%0d rdy=%0b busy=%0b want cnt=0 rdy=1 busy=0", done_cnt, in_ready, busy); end
        step(); step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_hold got v=%0b want 0", out_valid); end
        rst_n = 1'b1;
        step();
        send(8'h01, 8'h01, 8'hC8);
        step();
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h00) begin errors++; $display("FAIL arst_after got v=%0b d=%h want v=1 d=00", out_valid, out_data); end
        step();
        checks++; if (done_cnt !== 8'd1) begin errors++; $display("FAIL arst_after_cnt got %0d want 1", done_cnt); end
        out_ready = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        test_reset();
        test_wrap();
        test_basic();
        test_rand_indep();
        test_backpressure();
        test_clear_collision();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
